// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back normally owns the port, and a
// bounded-wait counter forces a grant to the long-latency unit so it cannot starve.
module wb_port_arbiter #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              lu_valid_i,
   input  logic [ADDR_W-1:0] lu_addr_i,
   input  logic [DATA_W-1:0] lu_data_i,
   output logic              lu_ready_o,
   output logic              stall_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_addr_o,
   output logic [DATA_W-1:0] rf_data_o
);

   localparam logic [CNT_W-1:0] MaxCnt      = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] LastRefusal = CNT_W'(MAX_WAIT - 1);

   logic              wb_req, lu_req;
   logic              grant_lu, grant_wb, waw_drop, lu_ready;
   logic              force_q, force_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;

   assign wb_req = wb_we_i && (wb_addr_i != '0);
   assign lu_req = lu_valid_i;

   // Grant priority: forced LU, then pipeline, then LU in an idle slot.
   always_comb begin
      grant_lu = 1'b0;
      grant_wb = 1'b0;
      if (force_q && lu_req) begin
         grant_lu = 1'b1;
      end else if (wb_req) begin
         grant_wb = 1'b1;
      end else if (lu_req) begin
         grant_lu = 1'b1;
      end
   end

   // A pending LU result aimed at the register the pipeline is writing now is already stale.
   assign waw_drop   = grant_wb && lu_req && !force_q && (lu_addr_i == wb_addr_i);
   assign lu_ready   = grant_lu || waw_drop;
   assign lu_ready_o = lu_ready && !rst_i;

   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (grant_lu) begin
         if (lu_addr_i != '0) begin
            rf_we_d   = 1'b1;
            rf_addr_d = lu_addr_i;
            rf_data_d = lu_data_i;
         end
      end else if (grant_wb) begin
         rf_we_d   = 1'b1;
         rf_addr_d = wb_addr_i;
         rf_data_d = wb_data_i;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!lu_req || lu_ready) begin
         cnt_d = '0;
      end else if (cnt_q < MaxCnt) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Force arms after MAX_WAIT refusals and lasts only until the LU is served.
   always_comb begin
      force_d = force_q;
      if (!lu_req || grant_lu) begin
         force_d = 1'b0;
      end else if (!lu_ready && (cnt_q == LastRefusal)) begin
         force_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         cnt_q     <= '0;
         force_q   <= 1'b0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         cnt_q     <= cnt_d;
         force_q   <= force_d;
      end
   end

   assign stall_o   = force_q;
   assign rf_we_o   = rf_we_q;
   assign rf_addr_o = rf_addr_q;
   assign rf_data_o = rf_data_q;

endmodule
